// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared core constants, fetch FSM states and helpers
//
// Contents:
//   ILEN              instruction / address width
//   BOOT_ADDR_DEFAULT reset fetch address
//   FIFO_DEPTH        fetch buffer entries
//   PAYLOAD_W         buffer entry width ({rdata, addr})
//   fetch_state_e     fetch control states
//   word_align()      clears the byte-offset bits of an address

package instr_fetch_pkg;

    localparam int          ILEN              = 32;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
    localparam int          FIFO_DEPTH        = 2;
    localparam int          PAYLOAD_W         = 2 * ILEN;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return {addr[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - two-entry fetch buffer holding {rdata, addr}
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   push        write push_data into the tail (ignored when full and not popping)
//   push_data   payload {instr word, byte address}
//   pop         remove the head entry (ignored when empty)
//   flush       empty the buffer; overrides push and pop
//   head_data   payload at the head (zero after reset)
//   count       number of valid entries (0..2)

module instr_fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [PAYLOAD_W-1:0] head_data,
    output logic [1:0]           count
);

    logic [PAYLOAD_W-1:0] mem [FIFO_DEPTH];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic                 do_pop;
    logic                 do_push;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'(FIFO_DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage for a 1-cycle fixed-latency ROM
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   rom_addr     byte address presented to the ROM
//   rom_rdata    ROM data, one cycle after rom_addr
//   jmp_valid    redirect request (flushes everything fetched so far)
//   jmp_addr     redirect target; low two bits ignored
//   instr_valid  an instruction is presented
//   instr_ready  decoder takes the instruction this cycle
//   instr_rdata  instruction word
//   instr_addr   byte address of instr_rdata

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [ILEN-1:0] rom_addr,
    input  logic [ILEN-1:0] rom_rdata,
    input  logic            jmp_valid,
    input  logic [ILEN-1:0] jmp_addr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_rdata,
    output logic [ILEN-1:0] instr_addr
);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [ILEN-1:0]      pc_q;
    logic [ILEN-1:0]      pc_d;
    logic [ILEN-1:0]      tag_q;
    logic [ILEN-1:0]      tag_d;
    logic                 inflight_q;
    logic                 inflight_d;
    logic [ILEN-1:0]      jmp_target;
    logic                 issue;
    logic                 can_issue;
    logic                 pop;
    logic                 push;
    logic [1:0]           fifo_count;
    logic [2:0]           occupancy;
    logic [PAYLOAD_W-1:0] head_data;

    assign jmp_target  = word_align(jmp_addr);
    assign instr_valid = (fifo_count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign instr_rdata = head_data[PAYLOAD_W-1:ILEN];
    assign instr_addr  = head_data[ILEN-1:0];

    // Returning data is written unless a redirect arrives in the same cycle;
    // that data belongs to the old path.
    assign push = inflight_q && !jmp_valid;

    // Slots already spoken for (buffered + on the way) minus the one leaving
    // now must leave room for another fetch, so the ROM never has to stall.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign can_issue = (occupancy < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                issue   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                issue   = can_issue;
                state_d = can_issue ? ST_RUN : ST_HOLD;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (jmp_valid) begin
            issue   = 1'b0;
            state_d = ST_RUN;
        end
    end

    // rom_addr tracks the PC while blocked, so it holds at the next address
    // to fetch; a redirect bypasses the PC to reach the ROM this cycle.
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        rom_addr   = pc_q;
        if (jmp_valid) begin
            rom_addr   = jmp_target;
            pc_d       = jmp_target + 32'd4;
            tag_d      = jmp_target;
            inflight_d = 1'b1;
        end else if (issue) begin
            pc_d       = pc_q + 32'd4;
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end
        if (!rstn) begin
            rom_addr = BOOT_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_BOOT;
            pc_q       <= BOOT_ADDR;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    instr_fetch_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({rom_rdata, tag_q}),
        .pop       (pop),
        .flush     (jmp_valid),
        .head_data (head_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch

module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata = 32'h0;
    logic        jmp_valid;
    logic [31:0] jmp_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic [31:0] instr_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nxfer    = 0;
    int          target   = 0;
    bit          ready_en = 1'b0;
    logic [31:0] exp_q [$];

    instr_fetch #(.BOOT_ADDR(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_rdata (instr_rdata),
        .instr_addr  (instr_addr)
    );

    always #5 clk = ~clk;

    // ROM model: word i = 32'h1000_0000 + i, one-cycle latency.
    always @(posedge clk) rom_rdata <= 32'h1000_0000 + (rom_addr >> 2);

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every transfer must match the next expected address.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rstn && instr_valid && instr_ready) begin
            nxfer++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr", instr_addr, e);
                check("sb_rdata", instr_rdata, rom_word(e));
            end else begin
                check("sb_unexpected", instr_addr, 32'hDEAD_BEEF);
            end
        end
    end

    task automatic upd_ready();
        instr_ready = ready_en && (nxfer < target);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_ready();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        jmp_valid = 1'b0;
        jmp_addr  = 32'h0;
        ready_en  = 1'b0;
        upd_ready();
        tick();
        tick();
        exp_q.delete();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rdata", instr_rdata, 32'h0);
        check("rst_addr", instr_addr, 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        check("rst_state", 32'(u_dut.state_q), 32'(ST_BOOT));
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int start;
        rstn        = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = 32'h0;
        instr_ready = 1'b0;

        // Streaming from reset with ready held high.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        ready_en = 1'b1; target = nxfer + 4; upd_ready();
        start = nxfer;
        check("t1_c0_valid", 32'(instr_valid), 32'd0);
        check("t1_c0_rom", rom_addr, 32'h0);
        tick();
        check("t1_c1_valid", 32'(instr_valid), 32'd0);
        check("t1_c1_rom", rom_addr, 32'h4);
        tick();
        check("t1_c2_valid", 32'(instr_valid), 32'd1);
        check("t1_c2_addr", instr_addr, 32'h0);
        repeat (4) tick();
        check("t1_rate", 32'(nxfer - start), 32'd4);
        drain("t1_drain", 20);

        // Backpressure: ready low for 5 cycles after first valid.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        tick(); tick();
        check("t2_c2_valid", 32'(instr_valid), 32'd1);
        repeat (4) tick();
        check("t2_hold_addr", instr_addr, 32'h0);
        check("t2_fifo_full", 32'(u_dut.fifo_count), 32'd2);
        check("t2_rom_frozen", rom_addr, 32'h8);
        ready_en = 1'b1; target = nxfer + 3; upd_ready();
        drain("t2_drain", 20);

        // Jump while addr 8 inflight; addr 4 waiting but not accepted.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        ready_en = 1'b1; target = nxfer + 1; upd_ready();
        tick(); tick(); tick();
        jmp_valid = 1'b1; jmp_addr = 32'h40;
        #1 check("t3_rom_jmp", rom_addr, 32'h40);
        tick();
        jmp_valid = 1'b0;
        #1 check("t3_bubble", 32'(instr_valid), 32'd0);
        target = nxfer + 2; upd_ready();
        tick();
        check("t3_valid_tgt", 32'(instr_valid), 32'd1);
        check("t3_addr_tgt", instr_addr, 32'h40);
        drain("t3_drain", 20);

        // Jump in the same cycle as the transfer of addr 4.
        do_reset();
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
        exp_q.push_back(32'h80); exp_q.push_back(32'h84);
        ready_en = 1'b1; target = nxfer + 4; upd_ready();
        tick(); tick(); tick();
        check("t4_addr4_shown", instr_addr, 32'h4);
        jmp_valid = 1'b1; jmp_addr = 32'h80;
        tick();
        jmp_valid = 1'b0;
        tick();
        check("t4_addr_tgt", instr_addr, 32'h80);
        drain("t4_drain", 20);

        // Back-to-back jumps, last one unaligned near the top of memory.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        ready_en = 1'b1; target = nxfer + 3; upd_ready();
        tick(); tick();
        jmp_valid = 1'b1; jmp_addr = 32'h200;
        tick();
        jmp_addr = 32'hFFFF_FFFE;
        #1 check("t5_rom_align", rom_addr, 32'hFFFF_FFFC);
        tick();
        jmp_valid = 1'b0;
        #1 check("t5_bubble", 32'(instr_valid), 32'd0);
        tick();
        check("t5_valid_tgt", 32'(instr_valid), 32'd1);
        drain("t5_drain", 20);

        // Reset with the buffer full.
        do_reset();
        repeat (6) tick();
        check("t6_fifo_full", 32'(u_dut.fifo_count), 32'd2);
        rstn = 1'b0;
        tick();
        check("t6_valid_rst", 32'(instr_valid), 32'd0);
        rstn = 1'b1;
        exp_q.push_back(32'h0);
        ready_en = 1'b1; target = nxfer + 1; upd_ready();
        tick(); tick();
        check("t6_valid_boot", 32'(instr_valid), 32'd1);
        check("t6_addr_boot", instr_addr, 32'h0);
        drain("t6_drain", 20);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first instruction byte address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port rom_addr  out  32  byte address to instruction ROM; maps to if_ram_1way ram_addr.
REQ-005 SHALL have port rom_rdata  in  32  ROM read data, valid one cycle after rom_addr; maps to ram_rdata.
REQ-006 SHALL have port jmp_valid  in  1  redirect request from execute stage.
REQ-007 SHALL have port jmp_addr  in  32  redirect target byte address.
REQ-008 SHALL have port instr_valid  out  1  instr_rdata/instr_addr hold a fetched instruction.
REQ-009 SHALL have port instr_ready  in  1  decoder accepts the instruction this cycle.
REQ-010 SHALL have port instr_rdata  out  32  instruction word.
REQ-011 SHALL have port instr_addr  out  32  byte address of instr_rdata.

Function
REQ-012 SHALL treat the ROM as fixed 1-cycle latency, non-stallable: data for address A appears on rom_rdata exactly one cycle after rom_addr=A.
REQ-013 SHALL keep a fetch PC; each issued fetch drives rom_addr=PC, sets inflight=1 with tag PC, and advances PC by 4.
REQ-014 SHALL, when inflight=1, write {rom_rdata, tag} into a 2-entry FIFO next cycle unless the fetch was cancelled.
REQ-015 SHALL issue a fetch only when FIFO occupancy + inflight + (pop this cycle ? -1 : 0) < 2; otherwise hold rom_addr unchanged, PC unchanged, inflight=0.
REQ-016 SHALL drive instr_valid = FIFO non-empty; instr_rdata/instr_addr from FIFO head; transfer on instr_valid & instr_ready.
REQ-017 SHALL keep instr_rdata/instr_addr stable while instr_valid=1 and instr_ready=0.
REQ-018 SHALL sustain one instruction per cycle with instr_ready held high; first instr_valid 2 cycles after reset release.
REQ-019 SHALL on jmp_valid: flush FIFO, cancel any inflight data (dropped next cycle), drive rom_addr=jmp_addr the same cycle, set PC=jmp_addr+4, inflight=1 tagged jmp_addr.
REQ-020 SHALL complete a transfer occurring in the same cycle as jmp_valid; the FIFO is flushed afterwards; no pre-jump entry appears later.
REQ-021 SHALL, on back-to-back jmp_valid, honour only the latest; instr_valid stays 0 until the last target's data arrives.
REQ-022 SHALL force jmp_addr[1:0] to 2'b00.
REQ-023 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-024 SHALL implement control as FSM: BOOT (first cycle after reset, issue BOOT_ADDR) -> RUN (issuing) <-> HOLD (issue blocked by REQ-015); jmp_valid from any state -> RUN.

Reset
REQ-025 SHALL with rstn=0: PC=BOOT_ADDR, rom_addr=BOOT_ADDR, inflight=0, FIFO empty, instr_valid=0, instr_rdata=0, instr_addr=0, state=BOOT.
REQ-026 SHALL discard all inflight and buffered data when rstn asserts mid-operation; no instruction from before reset is presented afterwards.

Structure
REQ-027 SHALL place BOOT_ADDR default, instruction width (32) and fetch FSM state enum in the shared core package.
REQ-028 SHALL implement the buffer as sub-module instr_fetch_fifo (2 entries, 64-bit payload, push/pop/flush, count output), same clk/rstn.

Verification
REQ-029 SHALL check reset release, ROM word i = 32'h1000_0000+i, ready=1 -> cycles 2..5 present (addr,rdata) = (0,10000000),(4,10000001),(8,10000002),(C,10000003).
REQ-030 SHALL check ready=0 for 5 cycles after first valid -> instr_addr=0 held, FIFO fills to 2, rom_addr frozen at 8; ready=1 -> 0,4,8 in order, no loss or duplicate.
REQ-031 SHALL check jmp_valid with jmp_addr=32'h40 while addr 8 inflight -> addr 8 never presented; next valid instr_addr=40, then 44.
REQ-032 SHALL check jmp_valid same cycle as transfer of addr 4 -> addr 4 counted once; next instr_addr = jump target 32'h80.
REQ-033 SHALL check jmp_addr=32'hFFFF_FFFE -> instr_addr FFFF_FFFC then 0000_0000.
REQ-034 SHALL check rstn=0 for 1 cycle with FIFO full -> instr_valid=0 next cycle; first post-reset instr_addr=BOOT_ADDR.
